// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle for the hazard/stall controller: ID/EX/MEM hazard
// inputs, the mul/div handshake and the stall/flush/enable outputs.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             uses_rt_id;
  logic             branch_id;
  logic             branch_taken_id;
  logic             mul_div_id;
  logic             hi_lo_id;
  logic [4:0]       rd_ex;
  logic             reg_write_ex;
  logic             mem_read_ex;
  logic [4:0]       rd_mem;
  logic             mem_read_mem;
  logic             mul_div_done;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             mul_div_start;
  logic             md_busy;
  logic             md_error;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs_id, rt_id, uses_rt_id, branch_id, branch_taken_id, mul_div_id, hi_lo_id,
           rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem, mul_div_done,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, mul_div_start, md_busy,
           md_error, stall_count
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, branch_id, branch_taken_id, mul_div_id, hi_lo_id,
           rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem, mul_div_done,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, mul_div_start, md_busy,
           md_error, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// MIPS front-end hazard detection, stall/flush generation, mul/div issue
// scheduling with a HI/LO interlock and watchdog, and a saturating stall counter.
module hazard_stall_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_stall_controller_if.slave hz
);
  typedef enum logic {IDLE, BUSY} md_state_t;

  localparam int TMR_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  md_state_t        state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic             error_q, error_set;
  logic [CNT_W-1:0] count_q;
  logic             ex_match, mem_match, stall, start;

  // Register zero is hardwired, so a producer targeting $0 never creates a hazard.
  assign ex_match  = (hz.rd_ex != 5'd0) &&
                     ((hz.rd_ex == hz.rs_id) || (hz.uses_rt_id && (hz.rd_ex == hz.rt_id)));
  assign mem_match = (hz.rd_mem != 5'd0) &&
                     ((hz.rd_mem == hz.rs_id) || (hz.uses_rt_id && (hz.rd_mem == hz.rt_id)));

  assign stall = (hz.mem_read_ex && hz.reg_write_ex && ex_match) ||
                 (hz.branch_id && hz.reg_write_ex && ex_match) ||
                 (hz.branch_id && hz.mem_read_mem && mem_match) ||
                 ((hz.mul_div_id || hz.hi_lo_id) && (state == BUSY) && !hz.mul_div_done);

  assign start = hz.mul_div_id && !stall;

  assign hz.pc_write      = !stall;
  assign hz.if_id_write   = !stall;
  assign hz.id_ex_bubble  = stall;
  assign hz.if_id_flush   = hz.branch_taken_id && !stall;
  assign hz.mul_div_start = start;
  assign hz.md_busy       = (state == BUSY);
  assign hz.md_error      = error_q;
  assign hz.stall_count   = count_q;

  // A start while busy only gets past the interlock together with Done, so it
  // simply restarts the watchdog for the newly issued operation.
  always_comb begin
    state_next = state;
    timer_next = timer;
    error_set  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = BUSY;
          timer_next = '0;
        end
      end
      BUSY: begin
        if (start) begin
          timer_next = '0;
        end else if (hz.mul_div_done) begin
          state_next = IDLE;
        end else if (timer == TMR_LAST) begin
          state_next = IDLE;
          error_set  = 1'b1;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (error_set) begin
        error_q <= 1'b1;
      end
      if (stall && (count_q != '1)) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: directed hazard/mul-div
// scenarios plus randomized traffic against a cycle-level reference model.
module tb_hazard_stall_controller;
  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic       taken;
    logic       mul_div;
    logic       hi_lo;
    logic [4:0] rd_ex;
    logic       reg_write_ex;
    logic       mem_read_ex;
    logic [4:0] rd_mem;
    logic       mem_read_mem;
    logic       done;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  in_t cur;
  bit  m_busy, m_error;
  int  m_count, m_cyc, m_deadline;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) hz();

  hazard_stall_controller #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  always #5 clk = ~clk;

  function automatic bit m_match(logic [4:0] r, in_t v);
    return (r != 5'd0) && ((r == v.rs) || (v.uses_rt && (r == v.rt)));
  endfunction

  function automatic bit m_stall(in_t v);
    bit load_use, br_ex, br_mem, hilo;
    load_use = v.mem_read_ex && v.reg_write_ex && m_match(v.rd_ex, v);
    br_ex    = v.branch && v.reg_write_ex && m_match(v.rd_ex, v);
    br_mem   = v.branch && v.mem_read_mem && m_match(v.rd_mem, v);
    hilo     = (v.mul_div || v.hi_lo) && m_busy && !v.done;
    return load_use || br_ex || br_mem || hilo;
  endfunction

  function automatic logic [6+CNT_W:0] exp_vec();
    bit s;
    s = m_stall(cur);
    return {!s, !s, s, cur.taken && !s, cur.mul_div && !s, m_busy, m_error, CNT_W'(m_count)};
  endfunction

  function automatic logic [6+CNT_W:0] got_vec();
    return {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.if_id_flush,
            hz.mul_div_start, hz.md_busy, hz.md_error, hz.stall_count};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_error = 0; m_count = 0; m_cyc = 0; m_deadline = 0;
  endtask

  task automatic set_inputs(input in_t v);
    cur = v;
    hz.rs_id = v.rs; hz.rt_id = v.rt; hz.uses_rt_id = v.uses_rt;
    hz.branch_id = v.branch; hz.branch_taken_id = v.taken;
    hz.mul_div_id = v.mul_div; hz.hi_lo_id = v.hi_lo;
    hz.rd_ex = v.rd_ex; hz.reg_write_ex = v.reg_write_ex; hz.mem_read_ex = v.mem_read_ex;
    hz.rd_mem = v.rd_mem; hz.mem_read_mem = v.mem_read_mem; hz.mul_div_done = v.done;
  endtask

  task automatic drive(input in_t v);
    set_inputs(v);
    @(negedge clk);
  endtask

  // Advance the reference model by one cycle, then let the DUT take the same edge.
  task automatic tick();
    bit s, st;
    s  = m_stall(cur);
    st = cur.mul_div && !s;
    if (s && (m_count < CNT_MAX)) m_count++;
    if (st) begin
      m_busy = 1;
      m_deadline = m_cyc + 1 + MD_TIMEOUT;
    end else if (m_busy && cur.done) begin
      m_busy = 0;
    end
    m_cyc++;
    if (m_busy && (m_cyc >= m_deadline)) begin
      m_busy = 0;
      m_error = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_t v;
    v = '0;
    model_reset();
    drive(v);
    checks++;
    if (got_vec() !== {1'b1, 1'b1, 5'b0, CNT_W'(0)})
      $display("[TB] FAIL reset_outputs: got %b expected %b", got_vec(), {1'b1, 1'b1, 5'b0, CNT_W'(0)});
    else passes++;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if ({hz.md_busy, hz.md_error, hz.stall_count} !== '0)
      $display("[TB] FAIL reset_release: got %b expected 0", {hz.md_busy, hz.md_error, hz.stall_count});
    else passes++;
  endtask

  task automatic test_zero_reg();
    in_t v;
    v = '0;
    v.uses_rt = 1; v.branch = 1; v.reg_write_ex = 1; v.mem_read_ex = 1; v.mem_read_mem = 1;
    drive(v);
    checks++;
    if ({hz.pc_write, hz.id_ex_bubble} !== 2'b10)
      $display("[TB] FAIL zero_reg_no_stall: got %b expected 10", {hz.pc_write, hz.id_ex_bubble});
    else passes++;
    tick();
  endtask

  task automatic test_load_use();
    in_t v;
    v = '0;
    v.rs = 5'd2; v.rt = 5'd4; v.uses_rt = 1;
    v.rd_ex = 5'd2; v.reg_write_ex = 1; v.mem_read_ex = 1;
    drive(v);
    checks++;
    if ({hz.pc_write, hz.if_id_write, hz.id_ex_bubble} !== 3'b001)
      $display("[TB] FAIL load_use_stall: got %b expected 001", {hz.pc_write, hz.if_id_write, hz.id_ex_bubble});
    else passes++;
    tick();
    v.rd_ex = 5'd0; v.reg_write_ex = 0; v.mem_read_ex = 0;
    v.rd_mem = 5'd2; v.mem_read_mem = 1;
    drive(v);
    checks++;
    if ({hz.pc_write, hz.id_ex_bubble, hz.stall_count} !== {2'b10, CNT_W'(1)})
      $display("[TB] FAIL load_use_release: got %b expected %b", {hz.pc_write, hz.id_ex_bubble, hz.stall_count}, {2'b10, CNT_W'(1)});
    else passes++;
    tick();
  endtask

  task automatic test_branch_load();
    in_t v;
    v = '0;
    v.rs = 5'd5; v.rt = 5'd0; v.uses_rt = 1; v.branch = 1; v.taken = 1;
    v.rd_ex = 5'd5; v.reg_write_ex = 1; v.mem_read_ex = 1;
    drive(v);
    checks++;
    if ({hz.id_ex_bubble, hz.if_id_flush} !== 2'b10)
      $display("[TB] FAIL branch_ex_stall: got %b expected 10", {hz.id_ex_bubble, hz.if_id_flush});
    else passes++;
    tick();
    v.rd_ex = 5'd0; v.reg_write_ex = 0; v.mem_read_ex = 0;
    v.rd_mem = 5'd5; v.mem_read_mem = 1;
    drive(v);
    checks++;
    if ({hz.id_ex_bubble, hz.if_id_flush} !== 2'b10)
      $display("[TB] FAIL branch_mem_stall: got %b expected 10", {hz.id_ex_bubble, hz.if_id_flush});
    else passes++;
    tick();
    v.rd_mem = 5'd0; v.mem_read_mem = 0;
    drive(v);
    checks++;
    if ({hz.id_ex_bubble, hz.if_id_flush, hz.stall_count} !== {2'b01, CNT_W'(3)})
      $display("[TB] FAIL branch_flush: got %b expected %b", {hz.id_ex_bubble, hz.if_id_flush, hz.stall_count}, {2'b01, CNT_W'(3)});
    else passes++;
    tick();
  endtask

  task automatic test_muldiv_hilo();
    in_t v;
    v = '0;
    v.mul_div = 1;
    drive(v);
    checks++;
    if (hz.mul_div_start !== 1'b1)
      $display("[TB] FAIL mult_start: got %b expected 1", hz.mul_div_start);
    else passes++;
    tick();
    checks++;
    if (hz.md_busy !== 1'b1) $display("[TB] FAIL mult_busy_rise: got %b expected 1", hz.md_busy);
    else passes++;
    v = '0;
    v.hi_lo = 1;
    for (int i = 1; i <= 9; i++) begin
      drive(v);
      checks++;
      if (hz.pc_write !== 1'b0) $display("[TB] FAIL mflo_stall_%0d: got %b expected 0", i, hz.pc_write);
      else passes++;
      tick();
    end
    v.done = 1;
    drive(v);
    checks++;
    if ({hz.pc_write, hz.id_ex_bubble, hz.md_busy} !== 3'b101)
      $display("[TB] FAIL mflo_release: got %b expected 101", {hz.pc_write, hz.id_ex_bubble, hz.md_busy});
    else passes++;
    tick();
    checks++;
    if ({hz.md_busy, hz.stall_count} !== {1'b0, CNT_W'(12)})
      $display("[TB] FAIL mult_busy_fall: got %b expected %b", {hz.md_busy, hz.stall_count}, {1'b0, CNT_W'(12)});
    else passes++;
  endtask

  task automatic test_back_to_back_timeout();
    in_t v;
    v = '0;
    v.mul_div = 1;
    drive(v);
    tick();
    v = '0;
    for (int i = 0; i < 3; i++) begin
      drive(v);
      tick();
    end
    v.mul_div = 1; v.done = 1;
    drive(v);
    checks++;
    if ({hz.mul_div_start, hz.id_ex_bubble} !== 2'b10)
      $display("[TB] FAIL b2b_start: got %b expected 10", {hz.mul_div_start, hz.id_ex_bubble});
    else passes++;
    tick();
    v = '0;
    // Busy must last the full watchdog window from the second start.
    for (int i = 0; i < MD_TIMEOUT + 4; i++) begin
      drive(v);
      checks++;
      if ({hz.md_busy, hz.md_error} !== {(i < MD_TIMEOUT), (i >= MD_TIMEOUT)})
        $display("[TB] FAIL timeout_cycle_%0d: got %b expected %b", i, {hz.md_busy, hz.md_error}, {(i < MD_TIMEOUT), (i >= MD_TIMEOUT)});
      else passes++;
      tick();
    end
    v.mul_div = 1;
    drive(v);
    checks++;
    if (hz.mul_div_start !== 1'b1) $display("[TB] FAIL issue_after_error: got %b expected 1", hz.mul_div_start);
    else passes++;
    tick();
    checks++;
    if ({hz.md_busy, hz.md_error} !== 2'b11)
      $display("[TB] FAIL error_sticky: got %b expected 11", {hz.md_busy, hz.md_error});
    else passes++;
  endtask

  task automatic test_async_reset();
    in_t v;
    v = '0;
    set_inputs(v);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hz.md_busy, hz.md_error, hz.stall_count} !== '0)
      $display("[TB] FAIL async_reset: got %b expected 0", {hz.md_busy, hz.md_error, hz.stall_count});
    else passes++;
    model_reset();
    #3 rst_n = 1'b1;
    tick();
    v.done = 1;
    drive(v);
    tick();
    checks++;
    if (hz.md_busy !== 1'b0) $display("[TB] FAIL done_after_reset: got %b expected 0", hz.md_busy);
    else passes++;
  endtask

  task automatic test_saturation();
    in_t v;
    v = '0;
    v.rs = 5'd7; v.rd_ex = 5'd7; v.reg_write_ex = 1; v.mem_read_ex = 1;
    for (int i = 1; i <= CNT_MAX + 5; i++) begin
      drive(v);
      tick();
      if (i == CNT_MAX || i == CNT_MAX + 5) begin
        checks++;
        if (hz.stall_count !== CNT_W'(CNT_MAX))
          $display("[TB] FAIL saturate_%0d: got %0d expected %0d", i, hz.stall_count, CNT_MAX);
        else passes++;
      end
    end
  endtask

  task automatic test_random();
    in_t v;
    for (int i = 0; i < 400; i++) begin
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.uses_rt = 1'($urandom_range(0, 1));
      v.branch = ($urandom_range(0, 3) == 0);
      v.taken = 1'($urandom_range(0, 1));
      v.mul_div = ($urandom_range(0, 3) == 0);
      v.hi_lo = ($urandom_range(0, 3) == 0);
      v.rd_ex = 5'($urandom_range(0, 3));
      v.reg_write_ex = 1'($urandom_range(0, 1));
      v.mem_read_ex = 1'($urandom_range(0, 1));
      v.rd_mem = 5'($urandom_range(0, 3));
      v.mem_read_mem = 1'($urandom_range(0, 1));
      v.done = ($urandom_range(0, 7) == 0);
      drive(v);
      checks++;
      if (got_vec() !== exp_vec())
        $display("[TB] FAIL random_%0d: got %b expected %b", i, got_vec(), exp_vec());
      else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_load_use();
    test_branch_load();
    test_muldiv_hilo();
    test_back_to_back_timeout();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
